// File: rtl/mem_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_loader_if
// Description : Byte-stream handshake and BRAM port bundle for the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stream_loader_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            byte_i;
    logic                  byte_valid_i;
    logic                  byte_ready_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic                  mem_wr_no;
    logic                  mem_rd_no;
    logic [DATA_WIDTH-1:0] mem_data_i;

    // master: the loader itself; slave: the byte source and BRAM around it
    modport master (
        input  byte_i,
        input  byte_valid_i,
        input  mem_data_i,
        output byte_ready_o,
        output mem_addr_o,
        output mem_data_o,
        output mem_wr_no,
        output mem_rd_no
    );

    modport slave (
        output byte_i,
        output byte_valid_i,
        output mem_data_i,
        input  byte_ready_o,
        input  mem_addr_o,
        input  mem_data_o,
        input  mem_wr_no,
        input  mem_rd_no
    );
endinterface
`default_nettype wire

// File: rtl/mem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_loader
// Description : Packs a byte stream into little-endian words, writes them to
//               BRAM, then reads the range back and compares checksums.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk_i,
    input  wire logic                  reset_ni,
    input  wire logic                  start_i,
    input  wire logic [ADDR_WIDTH-1:0] base_addr_i,
    input  wire logic [ADDR_WIDTH:0]   word_count_i,
    mem_stream_loader_if.master        bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [DATA_WIDTH-1:0]      checksum_o
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_BIW   = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_BIW-1:0]    c_LAST_BYTE = c_BIW'(c_BYTES - 1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_RD      = 3'd3,
        S_CAP     = 3'd4,
        S_CHECK   = 3'd5
    } state_t;

    state_t                r_state,    w_state;
    logic [ADDR_WIDTH-1:0] r_base,     w_base;
    logic [ADDR_WIDTH:0]   r_count,    w_count;
    logic [ADDR_WIDTH:0]   r_word_idx, w_word_idx;
    logic [c_BIW-1:0]      r_byte_idx, w_byte_idx;
    logic [DATA_WIDTH-1:0] r_word,     w_word;
    logic [DATA_WIDTH-1:0] r_checksum, w_checksum;
    logic [DATA_WIDTH-1:0] r_rd_sum,   w_rd_sum;
    logic [ADDR_WIDTH-1:0] r_addr,     w_addr;
    logic [DATA_WIDTH-1:0] r_data,     w_data;
    logic                  r_wr_n,     w_wr_n;
    logic                  r_rd_n,     w_rd_n;
    logic                  r_ready,    w_ready;
    logic                  r_busy,     w_busy;
    logic                  r_done,     w_done;
    logic                  r_error,    w_error;

    logic [DATA_WIDTH-1:0] w_word_asm;
    logic [ADDR_WIDTH-1:0] w_addr_cur;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [ADDR_WIDTH:0]   w_idx_inc;
    logic                  w_last;

    // Address arithmetic is ADDR_WIDTH wide so it wraps past the top of memory
    assign w_idx_inc  = r_word_idx + 1'b1;
    assign w_last     = (w_idx_inc == r_count);
    assign w_addr_cur = r_base + r_word_idx[ADDR_WIDTH-1:0];
    assign w_addr_nxt = r_base + w_idx_inc[ADDR_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_checksum <= '0;
            r_rd_sum   <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wr_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_base     <= w_base;
            r_count    <= w_count;
            r_word_idx <= w_word_idx;
            r_byte_idx <= w_byte_idx;
            r_word     <= w_word;
            r_checksum <= w_checksum;
            r_rd_sum   <= w_rd_sum;
            r_addr     <= w_addr;
            r_data     <= w_data;
            r_wr_n     <= w_wr_n;
            r_rd_n     <= w_rd_n;
            r_ready    <= w_ready;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_error    <= w_error;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_base     = r_base;
        w_count    = r_count;
        w_word_idx = r_word_idx;
        w_byte_idx = r_byte_idx;
        w_word     = r_word;
        w_checksum = r_checksum;
        w_rd_sum   = r_rd_sum;
        w_addr     = r_addr;
        w_data     = r_data;
        w_wr_n     = 1'b1;
        w_rd_n     = 1'b1;
        w_ready    = r_ready;
        w_busy     = r_busy;
        w_done     = r_done;
        w_error    = r_error;

        w_word_asm = r_word;
        w_word_asm[r_byte_idx*8 +: 8] = bus.byte_i;

        // Strobes, address and data are computed one state early so that
        // every BRAM-facing output comes straight from a flop.
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (word_count_i == '0) begin
                        w_done  = 1'b1;
                        w_error = 1'b0;
                    end else if (word_count_i > c_DEPTH) begin
                        w_done  = 1'b1;
                        w_error = 1'b1;
                    end else begin
                        w_base     = base_addr_i;
                        w_count    = word_count_i;
                        w_word_idx = '0;
                        w_byte_idx = '0;
                        w_word     = '0;
                        w_checksum = '0;
                        w_rd_sum   = '0;
                        w_done     = 1'b0;
                        w_error    = 1'b0;
                        w_ready    = 1'b1;
                        w_busy     = 1'b1;
                        w_state    = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (bus.byte_valid_i && r_ready) begin
                    w_word = w_word_asm;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_byte_idx = '0;
                        w_ready    = 1'b0;
                        w_wr_n     = 1'b0;
                        w_addr     = w_addr_cur;
                        w_data     = w_word_asm;
                        w_state    = S_WRITE;
                    end else begin
                        w_byte_idx = r_byte_idx + 1'b1;
                    end
                end
            end

            S_WRITE: begin
                w_checksum = r_checksum + r_data;
                if (w_last) begin
                    w_word_idx = '0;
                    w_rd_n     = 1'b0;
                    w_addr     = r_base;
                    w_state    = S_RD;
                end else begin
                    w_word_idx = w_idx_inc;
                    w_ready    = 1'b1;
                    w_state    = S_COLLECT;
                end
            end

            // BRAM read data is registered, so it is taken in CAP
            S_RD: begin
                w_state = S_CAP;
            end

            S_CAP: begin
                w_rd_sum = r_rd_sum + bus.mem_data_i;
                if (w_last) begin
                    w_word_idx = '0;
                    w_state    = S_CHECK;
                end else begin
                    w_word_idx = w_idx_inc;
                    w_rd_n     = 1'b0;
                    w_addr     = w_addr_nxt;
                    w_state    = S_RD;
                end
            end

            S_CHECK: begin
                w_done  = 1'b1;
                w_error = (r_rd_sum != r_checksum);
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.byte_ready_o = r_ready;
    assign bus.mem_addr_o   = r_addr;
    assign bus.mem_data_o   = r_data;
    assign bus.mem_wr_no    = r_wr_n;
    assign bus.mem_rd_no    = r_rd_n;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign error_o          = r_error;
    assign checksum_o       = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stream_loader
// Description : Directed bench for mem_stream_loader with a small BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stream_loader;

    logic        clk_i;
    logic        reset_ni;
    logic        start_i;
    logic [5:0]  base_addr_i;
    logic [6:0]  word_count_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] checksum_o;

    mem_stream_loader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    mem_stream_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .word_count_i (word_count_i),
        .bus          (bus),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .checksum_o   (checksum_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // BRAM model; optional bit-0 corruption on reads of address 1
    logic [31:0] r_mem [0:63];
    logic [31:0] r_rdata = '0;
    logic        corrupt = 1'b0;
    always @(posedge clk_i) begin
        if (!bus.mem_wr_no) r_mem[bus.mem_addr_o] <= bus.mem_data_o;
        if (!bus.mem_rd_no)
            r_rdata <= r_mem[bus.mem_addr_o] ^ {31'd0, corrupt && (bus.mem_addr_o == 6'd1)};
    end
    assign bus.mem_data_i = r_rdata;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte source and bus monitor share one process so their bookkeeping never races
    logic [7:0]  tx_q [$];
    logic [5:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [5:0]  rd_addr_q [$];
    int  n_acc = 0, first_wr_acc = -1, rdy_in_wr = 0, both_low = 0, n_strobe = 0;
    bit  rand_mode = 1'b0, gaps = 1'b0, phase = 1'b0, acc = 1'b0;

    initial begin
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = '0;
        forever begin
            @(negedge clk_i);
            if (acc && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                n_acc++;
            end
            if (bus.mem_wr_no === 1'b0) begin
                wr_addr_q.push_back(bus.mem_addr_o);
                wr_data_q.push_back(bus.mem_data_o);
                if (wr_addr_q.size() == 1) first_wr_acc = n_acc;
                if (bus.byte_ready_o === 1'b1) rdy_in_wr++;
                n_strobe++;
            end
            if (bus.mem_rd_no === 1'b0) begin
                rd_addr_q.push_back(bus.mem_addr_o);
                n_strobe++;
            end
            if (bus.mem_wr_no === 1'b0 && bus.mem_rd_no === 1'b0) both_low++;
            phase = ~phase;
            if (rand_mode) begin
                bus.byte_valid_i = 1'($urandom);
                bus.byte_i       = 8'($urandom);
            end else if (tx_q.size() > 0 && !(gaps && phase)) begin
                bus.byte_valid_i = 1'b1;
                bus.byte_i       = tx_q[0];
            end else begin
                bus.byte_valid_i = 1'b0;
            end
            acc = (bus.byte_valid_i === 1'b1) && (bus.byte_ready_o === 1'b1);
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clr();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        tx_q.delete();
        n_acc        = 0;
        first_wr_acc = -1;
        rdy_in_wr    = 0;
    endtask

    task automatic push_seq(input logic [7:0] step);
        for (int i = 1; i <= 8; i++) tx_q.push_back(8'(step * i));
    endtask

    task automatic run_load(input logic [5:0] base, input logic [6:0] cnt, output int lat);
        start_i      = 1'b1;
        base_addr_i  = base;
        word_count_i = cnt;
        tick();
        start_i = 1'b0;
        lat     = 0;
        while (!done_o && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_two(input string tag, input logic [5:0] a0, input logic [31:0] d0,
                             input logic [5:0] a1, input logic [31:0] d1);
        check({tag, "_nwr"}, wr_addr_q.size(), 2);
        check({tag, "_wa0"}, wr_addr_q[0], a0);
        check({tag, "_wd0"}, wr_data_q[0], d0);
        check({tag, "_wa1"}, wr_addr_q[1], a1);
        check({tag, "_wd1"}, wr_data_q[1], d1);
        check({tag, "_nrd"}, rd_addr_q.size(), 2);
        check({tag, "_ra0"}, rd_addr_q[0], a0);
        check({tag, "_ra1"}, rd_addr_q[1], a1);
        check({tag, "_done"}, done_o, 1'b1);
        check({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat;
        int k;
        int s0;

        // Reset with random inputs
        reset_ni  = 1'b0;
        rand_mode = 1'b1;
        repeat (2) begin
            start_i      = 1'($urandom);
            base_addr_i  = 6'($urandom);
            word_count_i = 7'($urandom);
            tick();
        end
        check("rst_wr_n",  bus.mem_wr_no, 1'b1);
        check("rst_rd_n",  bus.mem_rd_no, 1'b1);
        check("rst_ready", bus.byte_ready_o, 1'b0);
        check("rst_busy",  busy_o, 1'b0);
        check("rst_done",  done_o, 1'b0);
        check("rst_error", error_o, 1'b0);
        check("rst_addr",  bus.mem_addr_o, 6'd0);
        check("rst_data",  bus.mem_data_o, 32'd0);
        check("rst_csum",  checksum_o, 32'd0);
        check("rst_strb",  n_strobe, 0);
        rand_mode    = 1'b0;
        start_i      = 1'b0;
        base_addr_i  = '0;
        word_count_i = '0;
        reset_ni     = 1'b1;
        tick();
        tick();

        // Oversized count, then zero count
        s0 = n_strobe;
        start_i = 1'b1; word_count_i = 7'd65;
        tick();
        start_i = 1'b0;
        check("big_done",  done_o, 1'b1);
        check("big_error", error_o, 1'b1);
        check("big_busy",  busy_o, 1'b0);
        start_i = 1'b1; word_count_i = 7'd0;
        tick();
        start_i = 1'b0;
        check("zero_done",  done_o, 1'b1);
        check("zero_error", error_o, 1'b0);
        check("zero_busy",  busy_o, 1'b0);
        repeat (3) tick();
        check("nolen_strb", n_strobe - s0, 0);

        // Basic load
        clr(); push_seq(8'h11);
        run_load(6'd0, 7'd2, lat);
        check("basic_lat", lat, 15);
        check_two("basic", 6'd0, 32'h44332211, 6'd1, 32'h88776655);
        check("basic_csum",  checksum_o, 32'hCCAA8866);
        check("basic_error", error_o, 1'b0);
        check("basic_rdywr", rdy_in_wr, 0);
        check("basic_m1",    r_mem[1], 32'h88776655);

        // Address wrap
        clr(); push_seq(8'h01);
        run_load(6'd63, 7'd2, lat);
        check_two("wrap", 6'd63, 32'h04030201, 6'd0, 32'h08070605);
        check("wrap_csum",  checksum_o, 32'h0C0A0806);
        check("wrap_error", error_o, 1'b0);

        // Backpressure
        clr(); push_seq(8'h11); gaps = 1'b1;
        run_load(6'd0, 7'd2, lat);
        gaps = 1'b0;
        check_two("bp", 6'd0, 32'h44332211, 6'd1, 32'h88776655);
        check("bp_firstwr", first_wr_acc, 4);
        check("bp_rdywr",   rdy_in_wr, 0);
        check("bp_csum",    checksum_o, 32'hCCAA8866);
        check("bp_error",   error_o, 1'b0);

        // Corrupted read-back
        clr(); push_seq(8'h11); corrupt = 1'b1;
        run_load(6'd0, 7'd2, lat);
        corrupt = 1'b0;
        check("cor_done",  done_o, 1'b1);
        check("cor_error", error_o, 1'b1);
        check("cor_csum",  checksum_o, 32'hCCAA8866);

        // start pulsed mid-COLLECT is ignored
        clr(); push_seq(8'h11);
        start_i = 1'b1; base_addr_i = 6'd0; word_count_i = 7'd2;
        tick();
        start_i = 1'b0; lat = 0;
        repeat (2) begin tick(); lat++; end
        start_i = 1'b1; base_addr_i = 6'd20; word_count_i = 7'd1;
        tick(); lat++;
        start_i = 1'b0;
        while (!done_o && lat < 2000) begin tick(); lat++; end
        check("mid_lat", lat, 15);
        check_two("mid", 6'd0, 32'h44332211, 6'd1, 32'h88776655);
        check("mid_error", error_o, 1'b0);

        // Reset after two bytes of a word
        clr(); push_seq(8'h11);
        start_i = 1'b1; base_addr_i = 6'd5; word_count_i = 7'd1;
        tick();
        start_i = 1'b0;
        k = 0;
        while (n_acc < 2 && k < 50) begin tick(); k++; end
        check("abort_acc", n_acc, 2);
        reset_ni = 1'b0;
        tx_q.delete();
        tick(); tick();
        reset_ni = 1'b1;
        repeat (10) tick();
        check("abort_nwr",  wr_addr_q.size(), 0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_rdy",  bus.byte_ready_o, 1'b0);
        check("abort_done", done_o, 1'b0);

        check("both_low", both_low, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Upstream feeder for the Nx32 BRAM block. Accepts a byte stream (valid/ready), assembles little-endian DATA_WIDTH words and writes them to consecutive BRAM addresses using the BRAM's active-low write strobe.
- After the last write, re-reads the same range through the active-low read strobe and compares a read-back checksum against the write-side checksum. Reports done and error.
- Used by the console/boot path to preload program RAM before releasing the CPU.

Parameters:
- ADDR_WIDTH, 6, BRAM address width; the BRAM holds 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8. BYTES = DATA_WIDTH/8 (derived).

Ports:
- clk_i  in  1  clock, posedge.
- reset_ni  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle start pulse; honoured only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first word address; sampled on start.
- word_count_i  in  ADDR_WIDTH+1  number of words to load; sampled on start.
- byte_i  in  8  stream byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- mem_addr_o  out  ADDR_WIDTH  BRAM address.
- mem_data_o  out  DATA_WIDTH  BRAM write data.
- mem_wr_no  out  1  BRAM write enable, active low.
- mem_rd_no  out  1  BRAM read enable, active low.
- mem_data_i  in  DATA_WIDTH  BRAM read data; registered output of the BRAM, valid the cycle after mem_rd_no is low.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  sticky; set on completion; cleared by the next accepted start.
- error_o  out  1  sticky; valid when done_o=1.
- checksum_o  out  DATA_WIDTH  write-side sum of all words, modulo 2^DATA_WIDTH.

Behaviour:
- Reset (reset_ni=0 at a posedge): every output goes to its reset value.
  - mem_wr_no=1, mem_rd_no=1.
  - byte_ready_o, busy_o, done_o, error_o = 0.
  - mem_addr_o, mem_data_o, checksum_o = 0.
  - Internal counters and accumulators = 0; state = IDLE.
  - Reset mid-operation aborts immediately. A partially assembled word is discarded and never written.
- Only registered outputs. mem_wr_no and mem_rd_no are never low in the same cycle.
- States: IDLE, COLLECT, WRITE, RD, CAP, CHECK.
- IDLE:
  - start_i with word_count_i=0: done_o=1, error_o=0 next cycle. No strobes. Stays in IDLE.
  - start_i with word_count_i > 2^ADDR_WIDTH: done_o=1, error_o=1. No strobes. Stays in IDLE.
  - Otherwise: latch base and count; clear word_idx, byte_idx, checksum, rd_sum, done_o, error_o; go to COLLECT.
  - start_i outside IDLE is ignored.
- COLLECT:
  - byte_ready_o=1.
  - On byte_valid_i & byte_ready_o, byte_i goes into lane byte_idx. The first byte lands in bits [7:0].
  - After the BYTES-th accepted byte, go to WRITE; byte_ready_o=0 from that cycle.
  - Gaps in byte_valid_i stall with no side effects.
- WRITE:
  - Exactly one cycle with mem_wr_no=0.
  - mem_addr_o = (base + word_idx) mod 2^ADDR_WIDTH; addresses wrap past the top of memory.
  - mem_data_o = assembled word.
  - checksum += word.
  - word_idx increments. If word_idx reaches count, go to RD with word_idx=0; else go to COLLECT with byte_idx=0.
- RD:
  - One cycle with mem_rd_no=0 and mem_addr_o = (base + word_idx) mod 2^ADDR_WIDTH.
  - Next state is CAP.
- CAP:
  - rd_sum += mem_data_i.
  - word_idx increments. If word_idx reaches count, go to CHECK; else go back to RD.
- CHECK (one cycle):
  - done_o=1 and error_o=(rd_sum != checksum).
  - busy_o=0 from the next cycle; return to IDLE.
- Latency, with bytes presented every cycle: N words take N*(BYTES+1) + 2N + 1 cycles from the cycle after start to done_o high.
  - N=2, BYTES=4: 15 cycles.
- checksum_o holds its final value until the next accepted start.

Test Plan:
- Reset: hold reset_ni=0 for 2 cycles while driving all inputs randomly -> all outputs at reset values, mem_wr_no=mem_rd_no=1, no strobe observed.
- Basic load: base=0, count=2, bytes 11 22 33 44 55 66 77 88 on consecutive cycles -> writes mem[0]=44332211 and mem[1]=88776655; reads of 0 then 1; checksum_o=CCAA8866; done_o=1, error_o=0 exactly 15 cycles after start.
- Wrap: base=63, count=2, bytes 01..08 -> writes addr 63=04030201 then addr 0=08070605; reads of 63 then 0; error_o=0.
- Backpressure: same as basic load but byte_valid_i low on alternate cycles -> identical writes; no mem_wr_no=0 until the 4th byte is accepted; byte_ready_o=0 during WRITE.
- Corrupt read-back: the bench BRAM model XORs bit 0 on reads of addr 1 -> done_o=1, error_o=1, checksum_o=CCAA8866.
- Boundaries:
  - count=0 -> done_o=1 next cycle, no strobes.
  - count=65 -> done_o=1, error_o=1, no strobes.
  - start_i pulsed mid-COLLECT -> ignored.
  - reset_ni=0 after 2 bytes of a word -> no write ever issued, busy_o=0.
